seq_det_ctrl: RTL and testbench

Programmable serial pattern-detection controller that configures, arms, sequences and counts matches for a bit-serial Mealy sequence detector datapath (for example, the 1011 detector).
- Holds the pattern, its length and the overlap mode.
- Arms and disarms detection on command and qualifies input bits with a valid strobe.
- Counts matches and stops automatically after a programmed number of hits.
- Sits between a host configuration interface and the serial input stream.

---
 rtl/seq_det_ctrl.sv | 171 +++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector controller: config registers, arm/stop FSM, match counter.
// Optional valid-bit timeout counter is built only when SEQ_DET_CTRL_TIMEOUT_EN is defined.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TMO_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  input  logic [CNT_W-1:0]           cfg_target,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       x,
  input  logic                       x_valid,
  output logic                       y,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       timeout
);
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d, cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
`endif

  logic [PAT_W-1:0] cand, mask;
  logic             len_ok, fill_ok, tgt_hit, hit;

  // Only the top PAT_W-1 history bits matter: the oldest one is shifted out by cand.
  assign cand    = {hist_q, x};
  assign mask    = (PAT_W'(1) << len_q) - PAT_W'(1);
  assign len_ok  = (len_q != '0) && (len_q <= LEN_MAX);
  assign fill_ok = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
  assign tgt_hit = (tgt_q != '0) && (((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) == (CNT_W+1)'(tgt_q));
  assign hit     = (state_q == ARMED) && x_valid && !stop &&
                   (((cand ^ pat_q) & mask) == '0) && fill_ok;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    len_d   = len_q;
    fill_d  = fill_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          ovl_d = cfg_overlap;
          tgt_d = cfg_target;
        end else if (start) begin
          if (len_ok) begin
            state_d = ARMED;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
            tmo_d     = '0;
            timeout_d = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ARMED: begin
        err_d = cfg_we;
        if (stop) begin
          state_d = IDLE;
        end else if (x_valid) begin
          if (hit && !ovl_q) begin
            hist_d = '0;
            fill_d = '0;
          end else begin
            hist_d = cand[PAT_W-2:0];
            fill_d = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
          end
          if (hit) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (tgt_hit) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
            tmo_d = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_d == '1) begin
              state_d   = DONE;
              timeout_d = 1'b1;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign y         = hit;
  assign busy      = (state_q == ARMED);
  assign done      = done_q;
  assign cfg_err   = err_q;
  assign match_cnt = cnt_q;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = |{TMO_W{1'b0}};
`endif
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed, table-driven bench for seq_det_ctrl; expected values are hand-computed per vector.
// Timeout sequence is included only when SEQ_DET_CTRL_TIMEOUT_EN is defined.
module tb_seq_det_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  localparam int TMO_W = 3;
`else
  localparam int TMO_W = 12;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start, stop, x, x_valid;
  logic             y, busy, done, cfg_err, timeout;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .stop(stop),
    .x(x), .x_valid(x_valid), .y(y), .busy(busy), .done(done), .cfg_err(cfg_err),
    .match_cnt(match_cnt), .timeout(timeout)
  );

  typedef struct {
    logic       we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic [7:0] tgt;
    logic       st;
    logic       sp;
    logic       xb;
    logic       xv;
    logic       ey;
    logic       eb;
    logic       ed;
    logic       ee;
    logic [7:0] ec;
    logic       et;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t ctlv(input logic st, input logic sp, input logic xb, input logic xv,
                                input logic ey, input logic eb, input logic ed, input logic ee,
                                input logic [7:0] ec);
    vec_t v;
    v.we = 1'b0; v.pat = 8'h00; v.len = 4'd0; v.ovl = 1'b0; v.tgt = 8'h00;
    v.st = st; v.sp = sp; v.xb = xb; v.xv = xv;
    v.ey = ey; v.eb = eb; v.ed = ed; v.ee = ee; v.ec = ec; v.et = 1'b0;
    return v;
  endfunction

  function automatic vec_t cfgv(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                                input logic [7:0] tgt, input logic st, input logic eb,
                                input logic ed, input logic ee, input logic [7:0] ec);
    vec_t v;
    v = ctlv(st, 1'b0, 1'b0, 1'b0, 1'b0, eb, ed, ee, ec);
    v.we = 1'b1; v.pat = pat; v.len = len; v.ovl = ovl; v.tgt = tgt;
    return v;
  endfunction

  // One qualified bit: x value, expected y, busy, done, match_cnt afterwards.
  function automatic vec_t bv(input logic xb, input logic ey, input logic eb, input logic ed,
                              input logic [7:0] ec);
    return ctlv(1'b0, 1'b0, xb, 1'b1, ey, eb, ed, 1'b0, ec);
  endfunction

  // Unqualified cycle with x=1 on the wire, which must be ignored.
  function automatic vec_t gv(input logic [7:0] ec);
    return ctlv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ec);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    cfg_we      = v.we;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ovl;
    cfg_target  = v.tgt;
    start       = v.st;
    stop        = v.sp;
    x           = v.xb;
    x_valid     = v.xv;
    #1;
    checkOutput({tag, " y"}, 32'(y), 32'(v.ey));
    @(posedge clk);
    #1;
    checkOutput({tag, " busy"}, 32'(busy), 32'(v.eb));
    checkOutput({tag, " done"}, 32'(done), 32'(v.ed));
    checkOutput({tag, " cfg_err"}, 32'(cfg_err), 32'(v.ee));
    checkOutput({tag, " match_cnt"}, 32'(match_cnt), 32'(v.ec));
    checkOutput({tag, " timeout"}, 32'(timeout), 32'(v.et));
  endtask

  task automatic runVectors(input string phase);
    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("%s[%0d]", phase, i));
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset y", 32'(y), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset cfg_err", 32'(cfg_err), 32'd0);
    checkOutput("reset match_cnt", 32'(match_cnt), 32'd0);
    checkOutput("reset timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Start with unwritten config (len=0) is rejected.
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(ctlv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // 1011 overlapping, stream 1011011.
    vecs.push_back(cfgv(8'h0B, 4'd4, 1, 8'd0, 0, 0, 0, 0, 0));
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(0, 0, 1, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(1, 1, 1, 0, 1));
    vecs.push_back(bv(0, 0, 1, 0, 1)); vecs.push_back(bv(1, 0, 1, 0, 1));
    vecs.push_back(bv(1, 1, 1, 0, 2));
    // Config write while armed: rejected, old pattern still in force.
    vecs.push_back(cfgv(8'h03, 4'd2, 0, 8'd0, 0, 1, 0, 1, 2));
    vecs.push_back(bv(1, 0, 1, 0, 2)); vecs.push_back(bv(0, 0, 1, 0, 2));
    vecs.push_back(bv(1, 0, 1, 0, 2)); vecs.push_back(bv(1, 1, 1, 0, 3));
    vecs.push_back(ctlv(0, 1, 0, 0, 0, 0, 0, 0, 3));
    // Non-overlapping: only the first 1011 matches.
    vecs.push_back(cfgv(8'h0B, 4'd4, 0, 8'd0, 0, 0, 0, 0, 3));
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(0, 0, 1, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(1, 1, 1, 0, 1));
    vecs.push_back(bv(0, 0, 1, 0, 1)); vecs.push_back(bv(1, 0, 1, 0, 1));
    vecs.push_back(bv(1, 0, 1, 0, 1));
    vecs.push_back(ctlv(0, 1, 0, 0, 0, 0, 0, 0, 1));
    // Target 2: DONE after the 7th bit, later bits ignored.
    vecs.push_back(cfgv(8'h0B, 4'd4, 1, 8'd2, 0, 0, 0, 0, 1));
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(0, 0, 1, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(1, 1, 1, 0, 1));
    vecs.push_back(bv(0, 0, 1, 0, 1)); vecs.push_back(bv(1, 0, 1, 0, 1));
    vecs.push_back(bv(1, 1, 0, 1, 2));
    vecs.push_back(bv(1, 0, 0, 1, 2)); vecs.push_back(bv(0, 0, 0, 1, 2));
    vecs.push_back(bv(1, 0, 0, 1, 2)); vecs.push_back(bv(1, 0, 0, 1, 2));
    // Write plus start in DONE: write wins, stays in DONE.
    vecs.push_back(cfgv(8'h0B, 4'd4, 1, 8'd0, 1, 0, 1, 0, 2));
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    // Same stream with unqualified gaps.
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(gv(0));
    vecs.push_back(bv(0, 0, 1, 0, 0)); vecs.push_back(gv(0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(gv(0));
    vecs.push_back(bv(1, 1, 1, 0, 1)); vecs.push_back(gv(1));
    vecs.push_back(bv(0, 0, 1, 0, 1)); vecs.push_back(gv(1));
    vecs.push_back(bv(1, 0, 1, 0, 1)); vecs.push_back(gv(1));
    vecs.push_back(bv(1, 1, 1, 0, 2));
    // Start while armed is ignored (count not cleared).
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 2));
    vecs.push_back(ctlv(0, 1, 0, 0, 0, 0, 0, 0, 2));
    // Stop together with the matching 4th bit.
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(0, 0, 1, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0));
    vecs.push_back(ctlv(0, 1, 1, 1, 0, 0, 0, 0, 0));
    // Length beyond PAT_W is illegal.
    vecs.push_back(cfgv(8'h0B, 4'd9, 1, 8'd0, 0, 0, 0, 0, 0));
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 0, 0, 1, 0));
    runVectors("table");

    // Counter saturation with a 1-bit pattern.
    vecs.push_back(cfgv(8'h01, 4'd1, 1, 8'd0, 0, 0, 0, 0, 0));
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 300; i++) vecs.push_back(bv(1, 1, 1, 0, (i >= 254) ? 8'd255 : 8'(i + 1)));
    vecs.push_back(ctlv(0, 1, 0, 0, 0, 0, 0, 0, 255));
    runVectors("sat");

    // Reset in the middle of an armed stream.
    vecs.push_back(cfgv(8'h0B, 4'd4, 1, 8'd0, 0, 0, 0, 0, 255));
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(0, 0, 1, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(1, 1, 1, 0, 1));
    vecs.push_back(bv(0, 0, 1, 0, 1));
    runVectors("rstseq");
    @(negedge clk);
    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; stop = 1'b0; x = 1'b1; x_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    checkOutput("midrst cfg_err", 32'(cfg_err), 32'd0);
    checkOutput("midrst match_cnt", 32'(match_cnt), 32'd0);
    checkOutput("midrst timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("midrst y", 32'(y), 32'd0);
    rst = 1'b0; x = 1'b0; x_valid = 1'b0;
    // Config was cleared by the reset, so start is rejected again.
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 0, 0, 1, 0));
    runVectors("postrst");

`ifndef SEQ_DET_CTRL_TIMEOUT_EN
    // Full-width pattern 10110011.
    vecs.push_back(cfgv(8'hB3, 4'd8, 1, 8'd0, 0, 0, 0, 0, 0));
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(0, 0, 1, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(1, 0, 1, 0, 0));
    vecs.push_back(bv(0, 0, 1, 0, 0)); vecs.push_back(bv(0, 0, 1, 0, 0));
    vecs.push_back(bv(1, 0, 1, 0, 0)); vecs.push_back(bv(1, 1, 1, 0, 1));
    vecs.push_back(bv(1, 0, 1, 0, 1));
    vecs.push_back(ctlv(0, 1, 0, 0, 0, 0, 0, 0, 1));
    runVectors("len8");
`else
    // Seven unmatched valid bits expire the 3-bit timeout.
    vecs.push_back(cfgv(8'h0B, 4'd4, 1, 8'd0, 0, 0, 0, 0, 0));
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(bv(0, 0, 1, 0, 0));
    vecs.push_back(bv(0, 0, 0, 0, 0));
    vecs[vecs.size()-1].et = 1'b1;
    vecs.push_back(ctlv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs[vecs.size()-1].et = 1'b1;
    vecs.push_back(ctlv(1, 0, 0, 0, 0, 1, 0, 0, 0));
    runVectors("tmo");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
